// File: rtl/imm_decode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : deco_pkg
//  Brief    : Shared types and field positions for the decode immediate path.
//  Revision : 1.0 - initial release
// ============================================================================
package deco_pkg;

    typedef enum logic [1:0] {
        FMT_NONE = 2'b00,
        FMT_S8   = 2'b01,
        FMT_S16  = 2'b10,
        FMT_U8   = 2'b11
    } fmt_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        PFX_HELD = 1'b1
    } state_t;

    localparam logic [3:0] OP_PFX  = 4'hF;
    localparam int         OP_MSB  = 31;
    localparam int         OP_LSB  = 28;
    localparam int         FMT_MSB = 27;
    localparam int         FMT_LSB = 26;
    localparam int         PAY_MSB = 23;
    localparam int         PAY_W   = 24;

endpackage
`default_nettype wire

// File: rtl/imm_sext.sv
`default_nettype none
// ============================================================================
//  Module   : imm_sext
//  Brief    : Combinational sign/zero extender from W_IN to W_OUT bits.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_sext #(
    parameter int W_IN  = 16,
    parameter int W_OUT = 32
) (
    input  logic [W_IN-1:0]  din,
    input  logic             sgn,
    output logic [W_OUT-1:0] dout
);

    generate
        if (W_OUT > W_IN) begin : g_extend
            assign dout = {{(W_OUT - W_IN){sgn & din[W_IN-1]}}, din};
        end else begin : g_pass
            assign dout = din[W_OUT-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : imm_decode_ctrl
//  Brief    : Decode-stage immediate select/extend with PFX prefix merging.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_decode_ctrl
    import deco_pkg::*;
#(
    parameter int N  = 32,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [N-1:0]  out_imm,
    output logic          out_pfx_used,
    input  logic          flush,
    output logic          pfx_err
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PAY_W-1:0]   r_payload;
    logic [PAY_W-1:0]   w_payload_nxt;
    logic               r_out_valid;
    logic [IW-1:0]      r_out_instr;
    logic [N-1:0]       r_out_imm;
    logic               r_pfx_used;
    logic               r_pfx_err;

    logic               w_accept;
    logic               w_is_pfx;
    fmt_t               w_fmt;
    logic               w_load;
    logic               w_pfx_err_nxt;
    logic               w_used_nxt;
    logic [15:0]        w_ext_in;
    logic               w_ext_sgn;
    logic [N-1:0]       w_ext;
    logic [N-1:0]       w_merged;
    logic [N-1:0]       w_imm_nxt;

    // Flush blocks acceptance so a redirected word is never consumed.
    assign in_ready  = !flush && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_pfx  = (in_instr[OP_MSB:OP_LSB] == OP_PFX);
    assign w_fmt     = fmt_t'(in_instr[FMT_MSB:FMT_LSB]);

    always_comb begin
        w_ext_in  = '0;
        w_ext_sgn = 1'b0;
        case (w_fmt)
            FMT_S8:  begin w_ext_in = {{8{in_instr[7]}}, in_instr[7:0]}; w_ext_sgn = 1'b1; end
            FMT_S16: begin w_ext_in = in_instr[15:0];                    w_ext_sgn = 1'b1; end
            FMT_U8:  begin w_ext_in = {8'h00, in_instr[7:0]};            w_ext_sgn = 1'b0; end
            default: begin w_ext_in = '0;                                w_ext_sgn = 1'b0; end
        endcase
    end

    imm_sext #(
        .W_IN  (16),
        .W_OUT (N)
    ) u_sext (
        .din  (w_ext_in),
        .sgn  (w_ext_sgn),
        .dout (w_ext)
    );

    // Merged immediates are taken as-is, truncated to N bits.
    always_comb begin
        if (w_fmt == FMT_S16) begin
            w_merged = N'({r_payload[15:0], in_instr[15:0]});
        end else begin
            w_merged = N'({r_payload, in_instr[7:0]});
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_payload_nxt = r_payload;
        w_load        = 1'b0;
        w_pfx_err_nxt = 1'b0;
        w_used_nxt    = 1'b0;
        w_imm_nxt     = w_ext;
        if (w_accept) begin
            if (w_is_pfx) begin
                w_payload_nxt = in_instr[PAY_MSB:0];
                w_state_nxt   = PFX_HELD;
                w_pfx_err_nxt = (r_state == PFX_HELD);
            end else begin
                w_load      = 1'b1;
                w_state_nxt = IDLE;
                if (r_state == PFX_HELD) begin
                    if (w_fmt != FMT_NONE) begin
                        w_imm_nxt  = w_merged;
                        w_used_nxt = 1'b1;
                    end else begin
                        w_pfx_err_nxt = 1'b1;
                    end
                end
            end
        end
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_payload   <= '0;
            r_pfx_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_imm   <= '0;
            r_pfx_used  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_payload <= w_payload_nxt;
            r_pfx_err <= w_pfx_err_nxt;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_instr <= in_instr;
                r_out_imm   <= w_imm_nxt;
                r_pfx_used  <= w_used_nxt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_imm      = r_out_imm;
    assign out_pfx_used = r_pfx_used;
    assign pfx_err      = r_pfx_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_decode_ctrl
//  Brief    : Directed self-checking bench for imm_decode_ctrl (N=32 and N=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        flush;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic        out_pfx_used;
    logic        pfx_err;

    logic        in_ready16;
    logic        out_valid16;
    logic [31:0] out_instr16;
    logic [15:0] out_imm16;
    logic        out_pfx_used16;
    logic        pfx_err16;

    int vectors;
    int miscompares;

    imm_decode_ctrl #(.N(32), .IW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_imm      (out_imm),
        .out_pfx_used (out_pfx_used),
        .flush        (flush),
        .pfx_err      (pfx_err)
    );

    imm_decode_ctrl #(.N(16), .IW(32)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready16),
        .out_valid    (out_valid16),
        .out_ready    (out_ready),
        .out_instr    (out_instr16),
        .out_imm      (out_imm16),
        .out_pfx_used (out_pfx_used16),
        .flush        (flush),
        .pfx_err      (pfx_err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_instr !== 32'h0 ||
            out_pfx_used !== 1'b0 || pfx_err !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: valid=%b imm=%h instr=%h used=%b err=%b rdy=%b, want 0 0 0 0 0 1",
                     out_valid, out_imm, out_instr, out_pfx_used, pfx_err, in_ready);
        end
    endtask

    task automatic test_extension();
        logic [31:0] words [3] = '{32'h1400_00FF, 32'h1800_8001, 32'h1C00_00FF};
        logic [31:0] imms  [3] = '{32'hFFFF_FFFF, 32'hFFFF_8001, 32'h0000_00FF};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = words[i];
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_imm !== imms[i] || out_instr !== words[i] || out_pfx_used !== 1'b0) begin
                miscompares++;
                $display("FAIL ext[%0d]: valid=%b imm=%h instr=%h used=%b, want 1 %h %h 0",
                         i, out_valid, out_imm, out_instr, out_pfx_used, imms[i], words[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_prefix_merge();
        in_valid = 1'b1; in_instr = 32'hF012_3456;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || pfx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL pfx_no_beat: valid=%b err=%b, want 0 0", out_valid, pfx_err);
        end
        in_instr = 32'h1400_0078;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h1234_5678 || out_pfx_used !== 1'b1 || pfx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL merge: valid=%b imm=%h used=%b err=%b, want 1 12345678 1 0",
                     out_valid, out_imm, out_pfx_used, pfx_err);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h1400_0011;
        tick();
        in_instr = 32'h1400_0022;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'h11 || out_instr !== 32'h1400_0011) begin
                miscompares++;
                $display("FAIL stall[%0d]: rdy=%b valid=%b imm=%h instr=%h, want 0 1 00000011 14000011",
                         i, in_ready, out_valid, out_imm, out_instr);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: rdy=%b, want 1", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h22) begin
            miscompares++;
            $display("FAIL no_bubble: valid=%b imm=%h, want 1 00000022", out_valid, out_imm);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_prefix_misuse();
        in_valid = 1'b1; in_instr = 32'hF011_1111;
        tick();
        in_instr = 32'hF0AB_CDEF;
        tick();
        vectors++;
        if (pfx_err !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL double_pfx_err: err=%b valid=%b, want 1 0", pfx_err, out_valid);
        end
        in_instr = 32'h1400_0001;
        tick();
        vectors++;
        if (pfx_err !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'hABCD_EF01 || out_pfx_used !== 1'b1) begin
            miscompares++;
            $display("FAIL double_pfx_merge: err=%b valid=%b imm=%h used=%b, want 0 1 abcdef01 1",
                     pfx_err, out_valid, out_imm, out_pfx_used);
        end
        in_instr = 32'hF055_5555;
        tick();
        in_instr = 32'h1000_0000;
        tick();
        vectors++;
        if (pfx_err !== 1'b1 || out_valid !== 1'b1 || out_imm !== 32'h0 ||
            out_pfx_used !== 1'b0 || out_instr !== 32'h1000_0000) begin
            miscompares++;
            $display("FAIL pfx_none: err=%b valid=%b imm=%h used=%b instr=%h, want 1 1 0 0 10000000",
                     pfx_err, out_valid, out_imm, out_pfx_used, out_instr);
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (pfx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL pfx_err_width: err=%b, want 0", pfx_err);
        end
    endtask

    task automatic test_flush_reset();
        in_valid = 1'b1; in_instr = 32'hF077_7777;
        tick();
        in_instr = 32'h1400_0009; flush = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: rdy=%b, want 0", in_ready);
        end
        tick();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || pfx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: valid=%b err=%b, want 0 0", out_valid, pfx_err);
        end
        in_instr = 32'h1400_0005;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h5 || out_pfx_used !== 1'b0 || pfx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL after_flush: valid=%b imm=%h used=%b err=%b, want 1 00000005 0 0",
                     out_valid, out_imm, out_pfx_used, pfx_err);
        end
        out_ready = 1'b0; in_instr = 32'h1400_0033;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_instr !== 32'h0 ||
            out_pfx_used !== 1'b0 || pfx_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_held: valid=%b imm=%h instr=%h used=%b err=%b, want all 0",
                     out_valid, out_imm, out_instr, out_pfx_used, pfx_err);
        end
        in_valid = 1'b1; in_instr = 32'hF012_3456;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b1; in_instr = 32'h1400_0007;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_imm !== 32'h7 || out_pfx_used !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pfx: valid=%b imm=%h used=%b, want 1 00000007 0",
                     out_valid, out_imm, out_pfx_used);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_narrow();
        in_valid = 1'b1; in_instr = 32'hF000_00AA;
        tick();
        in_instr = 32'h1400_00BB;
        tick();
        vectors++;
        if (out_valid16 !== 1'b1 || out_imm16 !== 16'hAABB || out_pfx_used16 !== 1'b1) begin
            miscompares++;
            $display("FAIL narrow16: valid=%b imm=%h used=%b, want 1 aabb 1",
                     out_valid16, out_imm16, out_pfx_used16);
        end
        vectors++;
        if (out_imm !== 32'h0000_AABB) begin
            miscompares++;
            $display("FAIL narrow32_ref: imm=%h, want 0000aabb", out_imm);
        end
        in_instr = 32'h1800_8001;
        tick();
        vectors++;
        if (out_imm16 !== 16'h8001 || out_pfx_used16 !== 1'b0) begin
            miscompares++;
            $display("FAIL narrow_s16: imm=%h used=%b, want 8001 0", out_imm16, out_pfx_used16);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_extension();
        test_prefix_merge();
        test_backpressure();
        test_prefix_misuse();
        test_flush_reset();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
